// File: rtl/lmul_pkg.sv
// Shared state encoding and default widths for the sequential large-integer multiplier.
package lmul_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MUL     = 2'd1,
      RESOLVE = 2'd2,
      DONE    = 2'd3
   } lmul_state_t;

   localparam int LMUL_OP_W  = 1024;
   localparam int LMUL_DIG_W = 32;

endpackage

// File: rtl/csa_3to2.sv
// Combinational 3:2 carry-save compressor; the carry word comes out already
// shifted into its weight position and truncated to W bits.
module csa_3to2
   import lmul_pkg::*;
#(
   parameter int W = 2048
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [W-1:0] c,
   output logic [W-1:0] sum,
   output logic [W-1:0] carry
);

   assign sum   = a ^ b ^ c;
   assign carry = ((a & b) | (a & c) | (b & c)) << 1;

endmodule

// File: rtl/wallace_seq_mult.sv
// Digit-serial OP_W x OP_W multiplier with carry-save accumulation and one final add.
// Define LMUL_SIGNED_EN for two's complement operands and product.
module wallace_seq_mult
   import lmul_pkg::*;
#(
   parameter int OP_W  = LMUL_OP_W,
   parameter int DIG_W = LMUL_DIG_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OP_W-1:0]   in_a,
   input  logic [OP_W-1:0]   in_b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [2*OP_W-1:0] out_p,
   output logic              busy
);

   localparam int NDIG = OP_W / DIG_W;
   localparam int PW   = 2 * OP_W;
   localparam int KW   = $clog2(NDIG + 1);
`ifdef LMUL_SIGNED_EN
   localparam int AW   = OP_W + 1;
`else
   localparam int AW   = OP_W;
`endif

   generate
      if (OP_W % DIG_W != 0) begin : g_bad_width
         $error("wallace_seq_mult: OP_W must be a multiple of DIG_W");
      end
   endgenerate

   lmul_state_t         state_r, state_nxt_s;
   logic [AW-1:0]       a_r, a_mag_s;
   logic [OP_W-1:0]     b_r, b_mag_s;
   logic [PW-1:0]       sum_r, carry_r, pp_r;
   logic [PW-1:0]       pp_s, csa_sum_s, csa_carry_s, total_s, result_s;
   logic [AW+DIG_W-1:0] prod_s;
   logic [KW-1:0]       k_r;
   logic [PW-1:0]       out_p_r;
   logic                out_valid_r, busy_r;
   logic                accept_s, last_s;

   assign in_ready  = (state_r == IDLE) && !rst;
   assign accept_s  = in_valid && in_ready;
   // One extra MUL cycle flushes the registered partial product into the accumulators.
   assign last_s    = (k_r == KW'(NDIG));
   assign out_valid = out_valid_r;
   assign out_p     = out_p_r;
   assign busy      = busy_r;

   // b_r shifts down each cycle, so its low digit is always the current one and runs out as zero.
   assign prod_s = {{DIG_W{1'b0}}, a_r} * {{AW{1'b0}}, b_r[DIG_W-1:0]};
   assign pp_s   = PW'(prod_s) << (32'(k_r) * DIG_W);
   assign total_s = sum_r + carry_r;

   csa_3to2 #(.W(PW)) u_csa (
      .a     (sum_r),
      .b     (carry_r),
      .c     (pp_r),
      .sum   (csa_sum_s),
      .carry (csa_carry_s)
   );

`ifdef LMUL_SIGNED_EN
   logic              sign_r, sign_s;
   logic [OP_W:0]     a_ext_s;

   // Magnitudes and product sign of the incoming operands; A gets an extra bit for the most negative value.
   always_comb begin
      a_ext_s = {in_a[OP_W-1], in_a};
      if (in_a[OP_W-1]) begin
         a_mag_s = ~a_ext_s + {{OP_W{1'b0}}, 1'b1};
      end else begin
         a_mag_s = a_ext_s;
      end
      if (in_b[OP_W-1]) begin
         b_mag_s = ~in_b + {{(OP_W-1){1'b0}}, 1'b1};
      end else begin
         b_mag_s = in_b;
      end
      sign_s = in_a[OP_W-1] ^ in_b[OP_W-1];
   end

   // Sign-correct the resolved magnitude.
   always_comb begin
      if (sign_r) begin
         result_s = ~total_s + {{(PW-1){1'b0}}, 1'b1};
      end else begin
         result_s = total_s;
      end
   end
`else
   assign a_mag_s  = in_a;
   assign b_mag_s  = in_b;
   assign result_s = total_s;
`endif

   // Next-state decode.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) state_nxt_s = MUL;
            else          state_nxt_s = IDLE;
         end
         MUL: begin
            if (last_s) state_nxt_s = RESOLVE;
            else        state_nxt_s = MUL;
         end
         RESOLVE: state_nxt_s = DONE;
         DONE: begin
            if (out_ready) state_nxt_s = IDLE;
            else           state_nxt_s = DONE;
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // State register and datapath.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= IDLE;
         a_r         <= {AW{1'b0}};
         b_r         <= {OP_W{1'b0}};
         sum_r       <= {PW{1'b0}};
         carry_r     <= {PW{1'b0}};
         pp_r        <= {PW{1'b0}};
         k_r         <= {KW{1'b0}};
         out_p_r     <= {PW{1'b0}};
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
`ifdef LMUL_SIGNED_EN
         sign_r      <= 1'b0;
`endif
      end else begin
         state_r <= state_nxt_s;
         busy_r  <= (state_nxt_s == MUL) || (state_nxt_s == RESOLVE);
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  a_r     <= a_mag_s;
                  b_r     <= b_mag_s;
                  sum_r   <= {PW{1'b0}};
                  carry_r <= {PW{1'b0}};
                  pp_r    <= {PW{1'b0}};
                  k_r     <= {KW{1'b0}};
`ifdef LMUL_SIGNED_EN
                  sign_r  <= sign_s;
`endif
               end
            end
            MUL: begin
               sum_r   <= csa_sum_s;
               carry_r <= csa_carry_s;
               pp_r    <= pp_s;
               b_r     <= b_r >> DIG_W;
               k_r     <= k_r + {{(KW-1){1'b0}}, 1'b1};
            end
            RESOLVE: begin
               out_p_r     <= result_s;
               out_valid_r <= 1'b1;
            end
            DONE: begin
               if (out_ready) out_valid_r <= 1'b0;
            end
            default: out_valid_r <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_wallace_seq_mult.sv
// Scoreboard bench for wallace_seq_mult against a behavioural wide-multiply reference.
module tb_wallace_seq_mult;

   localparam int OP_W = 1024;
   localparam int PW   = 2 * OP_W;
   localparam int LAT  = 34;

   logic            clk = 1'b0;
   logic            rst, in_valid, in_ready, out_valid, out_ready, busy;
   logic [OP_W-1:0] in_a, in_b;
   logic [PW-1:0]   out_p;

   int            n_cmp = 0;
   int            n_bad = 0;
   logic [PW-1:0] sb_q[$];
   logic [PW-1:0] one = {{(PW-1){1'b0}}, 1'b1};

   always #5 clk = ~clk;

   wallace_seq_mult dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_p     (out_p),
      .busy      (busy)
   );

   function automatic logic [OP_W-1:0] dec2big(input string s);
      logic [OP_W-1:0] r;
      r = '0;
      for (int i = 0; i < s.len(); i++) r = r * OP_W'(10) + OP_W'(int'(s[i]) - 48);
      return r;
   endfunction

   function automatic logic [PW-1:0] ref_mul(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b);
      logic [PW-1:0] ea, eb;
`ifdef LMUL_SIGNED_EN
      ea = {{OP_W{a[OP_W-1]}}, a};
      eb = {{OP_W{b[OP_W-1]}}, b};
`else
      ea = {{OP_W{1'b0}}, a};
      eb = {{OP_W{1'b0}}, b};
`endif
      return ea * eb;
   endfunction

   function automatic logic [OP_W-1:0] rand_op();
      logic [OP_W-1:0] r;
      r = '0;
      for (int i = 0; i < OP_W / 32; i++) r = {r[OP_W-33:0], 32'($urandom)};
      return r;
   endfunction

   task automatic issue(input string name, input logic [OP_W-1:0] a, input logic [OP_W-1:0] b);
      bit ok;
      ok = 1'b0;
      in_a = a; in_b = b; in_valid = 1'b1;
      for (int t = 0; t < 200 && !ok; t++) begin
         if (in_ready === 1'b1) ok = 1'b1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL %s_accept: in_ready never seen high, required 1 within 200 cycles", name);
      end else begin
         sb_q.push_back(ref_mul(a, b));
      end
   endtask

   task automatic wait_out(input string name, input bit chk_busy, output logic [PW-1:0] got);
      int lat, busy_bad;
      logic [PW-1:0] exp;
      lat = 0; busy_bad = 0; got = '0;
      for (int n = 1; n <= LAT + 20; n++) begin
         @(posedge clk); #1;
         if (out_valid === 1'b1) begin lat = n; break; end
         if (busy !== 1'b1) busy_bad++;
      end
      n_cmp++;
      if (lat != LAT) begin
         n_bad++;
         $display("FAIL %s_latency: got %0d cycles (0 = none), required %0d", name, lat, LAT);
      end
      if (lat != 0) begin
         got = out_p;
         exp = (sb_q.size() > 0) ? sb_q.pop_front() : ~out_p;
         n_cmp++;
         if (got !== exp) begin
            n_bad++;
            $display("FAIL %s_product: got hi %h lo %h, required hi %h lo %h",
                     name, got[PW-1:PW-64], got[63:0], exp[PW-1:PW-64], exp[63:0]);
         end
         if (chk_busy) begin
            n_cmp++;
            if (busy_bad != 0 || busy !== 1'b0) begin
               n_bad++;
               $display("FAIL %s_busy: %0d low cycles while working, busy=%b at done, required 0 and 0",
                        name, busy_bad, busy);
            end
         end
      end
   endtask

   task automatic drain(input string name);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL %s_drain: out_valid=%b in_ready=%b, required 0 and 1", name, out_valid, in_ready);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || out_p !== {PW{1'b0}}) begin
         n_bad++;
         $display("FAIL reset_state: out_valid=%b busy=%b in_ready=%b out_p_lo=%h, required 0 0 0 0",
                  out_valid, busy, in_ready, out_p[63:0]);
      end
      rst = 1'b0;
      #1;
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_release: in_ready=%b, required 1", in_ready);
      end
   endtask

   task automatic test_t1();
      logic [PW-1:0] got;
      issue("t1", dec2big("7656767757656756578556555675567565788767875"),
                  dec2big("75675675667565456746456"));
      wait_out("t1", 1'b0, got);
      drain("t1");
   endtask

   task automatic test_all_ones();
      logic [PW-1:0] got, exp;
`ifdef LMUL_SIGNED_EN
      exp = one;
`else
      exp = ~(one << 1025) + (one << 1);
`endif
      issue("t2", {OP_W{1'b1}}, {OP_W{1'b1}});
      wait_out("t2", 1'b0, got);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL t2_const: got lo %h, required lo %h", got[63:0], exp[63:0]);
      end
      drain("t2");
   endtask

   task automatic test_zero();
      logic [PW-1:0] got;
      issue("t3", {OP_W{1'b0}}, rand_op());
      wait_out("t3", 1'b1, got);
      n_cmp++;
      if (got !== {PW{1'b0}}) begin
         n_bad++;
         $display("FAIL t3_zero: got lo %h, required 0", got[63:0]);
      end
      drain("t3");
   endtask

   task automatic test_backpressure();
      logic [PW-1:0]   held;
      logic [OP_W-1:0] a2, b2;
      int              bad;
      issue("t4", rand_op(), rand_op());
      wait_out("t4", 1'b1, held);
      a2 = rand_op(); b2 = rand_op();
      in_a = a2; in_b = b2; in_valid = 1'b1; bad = 0;
      repeat (5) begin
         @(posedge clk); #1;
         if (out_p !== held || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
      end
      n_cmp++;
      if (bad != 0) begin
         n_bad++;
         $display("FAIL t4_hold: %0d cycles disturbed, required 0", bad);
      end
      drain("t4");
      n_cmp++;
      if (out_p !== held || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL t4_retain: out_p_lo=%h busy=%b, required lo %h and 0", out_p[63:0], busy, held[63:0]);
      end
      sb_q.push_back(ref_mul(a2, b2));
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_cmp++;
      if (busy !== 1'b1 || in_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL t4_accept: busy=%b in_ready=%b, required 1 and 0", busy, in_ready);
      end
      wait_out("t4b", 1'b1, held);
      drain("t4b");
   endtask

   task automatic test_abort();
      logic [PW-1:0] got, stale;
      issue("t5", rand_op(), rand_op());
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      stale = sb_q.pop_back();
      n_cmp++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL t5_abort: out_valid=%b busy=%b, required 0 and 0", out_valid, busy);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      n_cmp++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || stale === out_p) begin
         n_bad++;
         $display("FAIL t5_release: in_ready=%b out_valid=%b, required 1 and 0", in_ready, out_valid);
      end
      issue("t5b", OP_W'(3), OP_W'(5));
      wait_out("t5b", 1'b0, got);
      n_cmp++;
      if (got !== PW'(15)) begin
         n_bad++;
         $display("FAIL t5_value: got lo %h, required lo %h", got[63:0], 64'd15);
      end
      drain("t5b");
   endtask

   task automatic test_minus_one();
      logic [PW-1:0] got, exp;
`ifdef LMUL_SIGNED_EN
      exp = ~(one << 1);
`else
      exp = (one << 1025) + (one << 1024) - ((one << 1) + one);
`endif
      issue("t6", {OP_W{1'b1}}, OP_W'(3));
      wait_out("t6", 1'b0, got);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL t6_const: got hi %h lo %h, required hi %h lo %h",
                  got[PW-1:PW-64], got[63:0], exp[PW-1:PW-64], exp[63:0]);
      end
      drain("t6");
   endtask

   task automatic test_back_to_back();
      logic [PW-1:0] got;
      for (int i = 0; i < 3; i++) begin
         issue("b2b", rand_op(), rand_op());
         wait_out("b2b", 1'b1, got);
         drain("b2b");
      end
      issue("b2b_small", OP_W'(32'hFFFF_FFFF), {OP_W{1'b1}} >> 5);
      wait_out("b2b_small", 1'b0, got);
      drain("b2b_small");
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_t1();
      test_all_ones();
      test_zero();
      test_backpressure();
      test_abort();
      test_minus_one();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
